// File: rtl/cp_corr_window_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cp_corr_window_pkg
// Purpose : Shared sample, product, energy and accumulator types for the
//           cyclic-prefix correlation window, and a constant clog2 helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cp_corr_window_pkg;

   localparam int unsigned CP_DW = 16;   // default sample width
   localparam int unsigned CP_L  = 16;   // default window (CP) length

   // Ceiling log2 usable in constant expressions (clog2(1) = 0).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int unsigned CP_PW = 2 * CP_DW + 1;
   localparam int unsigned CP_AW = CP_PW + clog2(CP_L);

   typedef logic signed [CP_DW-1:0] r_t;
   typedef logic signed [CP_PW-1:0] prod_t;
   typedef logic        [CP_PW-1:0] energy_t;
   typedef logic signed [CP_AW-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/cp_corr_window_cplx_conj_mult.sv
`default_nettype none
// ============================================================================
// Module  : cp_corr_window_cplx_conj_mult
// Purpose : Registered r * conj(r_dN) product and combined energy of the
//           pair, with the valid strobe passed through one register stage.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           valid_i       - input pair valid
//           r_re_i/r_im_i - r[n]        (signed DW)
//           dn_re_i/dn_im_i - r[n-N]    (signed DW)
//           valid_o       - registered valid
//           pr_o/pi_o     - real/imag of r*conj(dN) (signed 2DW+1)
//           e_o           - |r|^2 + |dN|^2 (unsigned 2DW+1)
// Revision: 1.0 - initial release
// ============================================================================
module cp_corr_window_cplx_conj_mult
   import cp_corr_window_pkg::*;
#(
   parameter  int DW = CP_DW,
   localparam int PW = 2 * DW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic [DW-1:0] r_re_i,
   input  logic [DW-1:0] r_im_i,
   input  logic [DW-1:0] dn_re_i,
   input  logic [DW-1:0] dn_im_i,
   output logic          valid_o,
   output logic [PW-1:0] pr_o,
   output logic [PW-1:0] pi_o,
   output logic [PW-1:0] e_o
);

   // Operands widened to the product width first so every product and sum
   // is exact; the worst case (-2^(DW-1) everywhere) still fits in PW bits.
   logic signed [PW-1:0] r_re_x, r_im_x, dn_re_x, dn_im_x;
   logic signed [PW-1:0] pr_d, pi_d;
   logic        [PW-1:0] e_d;

   logic          valid_q;
   logic [PW-1:0] pr_q, pi_q, e_q;

   assign r_re_x  = {{(PW-DW){r_re_i[DW-1]}},  r_re_i};
   assign r_im_x  = {{(PW-DW){r_im_i[DW-1]}},  r_im_i};
   assign dn_re_x = {{(PW-DW){dn_re_i[DW-1]}}, dn_re_i};
   assign dn_im_x = {{(PW-DW){dn_im_i[DW-1]}}, dn_im_i};

   assign pr_d = r_re_x * dn_re_x + r_im_x * dn_im_x;
   assign pi_d = r_im_x * dn_re_x - r_re_x * dn_im_x;
   // Sum of squares is non-negative; up to 2^(2DW) needs the top bit as
   // magnitude, hence the unsigned interpretation.
   assign e_d  = r_re_x * r_re_x + r_im_x * r_im_x
               + dn_re_x * dn_re_x + dn_im_x * dn_im_x;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pr_q    <= '0;
         pi_q    <= '0;
         e_q     <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            pr_q <= pr_d;
            pi_q <= pi_d;
            e_q  <= e_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign pr_o    = pr_q;
   assign pi_o    = pi_q;
   assign e_o     = e_q;

endmodule
`default_nettype wire

// File: rtl/cp_corr_window.sv
`default_nettype none
// ============================================================================
// Module  : cp_corr_window
// Purpose : Sliding-window cyclic-prefix correlation over the last L accepted
//           sample pairs: gamma = sum r*conj(r_dN), phi = sum energy / 2.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           in_valid          - input pair valid (from delay_n stage)
//           r_real/r_imag     - r[n]
//           r_dN_real/r_dN_imag - r[n-N]
//           corr_valid        - one pulse per accepted input
//           gamma_re/gamma_im - signed windowed correlation (AW bits)
//           phi               - unsigned windowed energy, halved (AW bits)
//           window_full       - high once L samples are in the window
// Revision: 1.0 - initial release
// ============================================================================
module cp_corr_window
   import cp_corr_window_pkg::*;
#(
   parameter  int DW = CP_DW,
   parameter  int L  = CP_L,
   parameter  int LW = $clog2(L) + 1,
   localparam int AW = 2 * DW + 1 + clog2(L)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] r_real,
   input  logic [DW-1:0] r_imag,
   input  logic [DW-1:0] r_dN_real,
   input  logic [DW-1:0] r_dN_imag,
   output logic          corr_valid,
   output logic [AW-1:0] gamma_re,
   output logic [AW-1:0] gamma_im,
   output logic [AW-1:0] phi,
   output logic          window_full
);

   localparam int PW   = 2 * DW + 1;
   localparam int PTRW = $clog2(L);

   // Stage 1 outputs
   logic          s1_valid;
   logic [PW-1:0] s1_pr, s1_pi, s1_e;

   // Circular buffer of the last L stage-1 results
   logic [PW-1:0] buf_pr_q [L];
   logic [PW-1:0] buf_pi_q [L];
   logic [PW-1:0] buf_e_q  [L];

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]   fill_q, fill_d;
   logic [AW-1:0]   acc_re_q, acc_re_d;
   logic [AW-1:0]   acc_im_q, acc_im_d;
   logic [AW-1:0]   acc_e_q,  acc_e_d;
   logic [AW-1:0]   phi_q;
   logic            corr_valid_q, window_full_q;

   logic [PW-1:0] old_pr, old_pi, old_e;

   cp_corr_window_cplx_conj_mult #(
      .DW (DW)
   ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .valid_i (in_valid),
      .r_re_i  (r_real),
      .r_im_i  (r_imag),
      .dn_re_i (r_dN_real),
      .dn_im_i (r_dN_imag),
      .valid_o (s1_valid),
      .pr_o    (s1_pr),
      .pi_o    (s1_pi),
      .e_o     (s1_e)
   );

   // The slot about to be overwritten holds the sample leaving the window.
   // Buffer is cleared on reset, so the first L updates subtract zero.
   assign old_pr = buf_pr_q[wr_ptr_q];
   assign old_pi = buf_pi_q[wr_ptr_q];
   assign old_e  = buf_e_q[wr_ptr_q];

   assign wr_ptr_d = (wr_ptr_q == PTRW'(L - 1)) ? '0 : wr_ptr_q + PTRW'(1);
   assign fill_d   = (fill_q == LW'(L)) ? fill_q : fill_q + LW'(1);

   // Products are signed, energies unsigned; widen accordingly. The
   // accumulator width absorbs the full-window worst case without wrap.
   assign acc_re_d = acc_re_q
                   + {{(AW-PW){s1_pr[PW-1]}}, s1_pr}
                   - {{(AW-PW){old_pr[PW-1]}}, old_pr};
   assign acc_im_d = acc_im_q
                   + {{(AW-PW){s1_pi[PW-1]}}, s1_pi}
                   - {{(AW-PW){old_pi[PW-1]}}, old_pi};
   assign acc_e_d  = acc_e_q
                   + {{(AW-PW){1'b0}}, s1_e}
                   - {{(AW-PW){1'b0}}, old_e};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            buf_pr_q[i] <= '0;
            buf_pi_q[i] <= '0;
            buf_e_q[i]  <= '0;
         end
         wr_ptr_q      <= '0;
         fill_q        <= '0;
         acc_re_q      <= '0;
         acc_im_q      <= '0;
         acc_e_q       <= '0;
         phi_q         <= '0;
         corr_valid_q  <= 1'b0;
         window_full_q <= 1'b0;
      end else begin
         corr_valid_q <= s1_valid;
         if (s1_valid) begin
            buf_pr_q[wr_ptr_q] <= s1_pr;
            buf_pi_q[wr_ptr_q] <= s1_pi;
            buf_e_q[wr_ptr_q]  <= s1_e;
            wr_ptr_q           <= wr_ptr_d;
            fill_q             <= fill_d;
            acc_re_q           <= acc_re_d;
            acc_im_q           <= acc_im_d;
            acc_e_q            <= acc_e_d;
            phi_q              <= acc_e_d >> 1;
            window_full_q      <= (fill_d == LW'(L));
         end
      end
   end

   assign corr_valid  = corr_valid_q;
   assign gamma_re    = acc_re_q;
   assign gamma_im    = acc_im_q;
   assign phi         = phi_q;
   assign window_full = window_full_q;

endmodule
`default_nettype wire

// File: tb/tb_cp_corr_window.sv
`default_nettype none
// ============================================================================
// Module  : tb_cp_corr_window
// Purpose : Self-checking bench for cp_corr_window. A window model keeps the
//           raw input pairs of the last L accepted samples and recomputes the
//           sums from scratch for every sample.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_cp_corr_window;

   localparam int DW = 16;
   localparam int L  = 16;
   localparam int AW = 2 * DW + 1 + $clog2(L);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] r_real, r_imag, r_dN_real, r_dN_imag;
   logic          corr_valid;
   logic [AW-1:0] gamma_re, gamma_im, phi;
   logic          window_full;

   cp_corr_window #(
      .DW (DW),
      .L  (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .r_real      (r_real),
      .r_imag      (r_imag),
      .r_dN_real   (r_dN_real),
      .r_dN_imag   (r_dN_imag),
      .corr_valid  (corr_valid),
      .gamma_re    (gamma_re),
      .gamma_im    (gamma_im),
      .phi         (phi),
      .window_full (window_full)
   );

   always #5 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   string phase  = "init";

   // Window model: raw inputs of the last L accepted samples.
   int     q_rr[$], q_ri[$], q_dr[$], q_di[$];
   int     n_acc;
   // Result of the sample accepted at the previous edge (due at this edge)
   logic   pend_v, pend_wf;
   longint pend_gre, pend_gim, pend_phi;
   // Values the outputs must currently show
   logic   cur_wf;
   longint cur_gre, cur_gim, cur_phi;

   function automatic int rnd();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      q_rr.delete(); q_ri.delete(); q_dr.delete(); q_di.delete();
      n_acc  = 0;
      pend_v = 1'b0; pend_wf = 1'b0;
      pend_gre = 0; pend_gim = 0; pend_phi = 0;
      cur_wf = 1'b0;
      cur_gre = 0; cur_gim = 0; cur_phi = 0;
   endtask

   task automatic model_accept(input int rr, input int ri, input int dr, input int di);
      longint sr, si, se;
      q_rr.push_back(rr); q_ri.push_back(ri);
      q_dr.push_back(dr); q_di.push_back(di);
      if (q_rr.size() > L) begin
         void'(q_rr.pop_front()); void'(q_ri.pop_front());
         void'(q_dr.pop_front()); void'(q_di.pop_front());
      end
      n_acc++;
      sr = 0; si = 0; se = 0;
      for (int i = 0; i < q_rr.size(); i++) begin
         // r * conj(dN) = (a+jb)(c-jd) = (ac+bd) + j(bc-ad)
         sr += longint'(q_rr[i]) * q_dr[i] + longint'(q_ri[i]) * q_di[i];
         si += longint'(q_ri[i]) * q_dr[i] - longint'(q_rr[i]) * q_di[i];
         se += longint'(q_rr[i]) * q_rr[i] + longint'(q_ri[i]) * q_ri[i]
             + longint'(q_dr[i]) * q_dr[i] + longint'(q_di[i]) * q_di[i];
      end
      pend_v   = 1'b1;
      pend_gre = sr;
      pend_gim = si;
      pend_phi = se / 2;
      pend_wf  = (n_acc >= L);
   endtask

   task automatic check_outputs();
      chk("corr_valid", {63'd0, corr_valid}, {63'd0, pend_v});
      if (pend_v) begin
         cur_gre = pend_gre; cur_gim = pend_gim;
         cur_phi = pend_phi; cur_wf  = pend_wf;
      end
      chk("gamma_re", $signed(gamma_re), cur_gre);
      chk("gamma_im", $signed(gamma_im), cur_gim);
      chk("phi", {{(64-AW){1'b0}}, phi}, cur_phi);
      chk("window_full", {63'd0, window_full}, {63'd0, cur_wf});
   endtask

   // One clock cycle: drive inputs, let the edge pass, check, update model.
   task automatic cyc(input logic v, input int rr, input int ri, input int dr, input int di);
      in_valid  = v;
      r_real    = DW'(rr);
      r_imag    = DW'(ri);
      r_dN_real = DW'(dr);
      r_dN_imag = DW'(di);
      @(posedge clk);
      #1;
      check_outputs();
      if (v && !rst) model_accept(rr, ri, dr, di);
      else           pend_v = 1'b0;
   endtask

   // Asynchronous reset with valid random traffic still applied.
   task automatic do_reset(input int n);
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      for (int i = 0; i < n; i++) cyc(1'b1, rnd(), rnd(), rnd(), rnd());
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0;
      r_real = '0; r_imag = '0; r_dN_real = '0; r_dN_imag = '0;
      model_reset();
      #2;

      phase = "reset";
      do_reset(4);

      phase = "ramp";
      for (int k = 1; k <= 20; k++) cyc(1'b1, 100, 0, 100, 0);
      cyc(1'b0, 0, 0, 0, 0);
      chk("ramp_gre", $signed(gamma_re), 64'sd160000);
      chk("ramp_gim", $signed(gamma_im), 64'sd0);
      chk("ramp_phi", {{(64-AW){1'b0}}, phi}, 64'sd160000);

      phase = "quad";
      do_reset(2);
      for (int k = 1; k <= 16; k++) cyc(1'b1, 0, 100, 100, 0);
      cyc(1'b0, 0, 0, 0, 0);
      chk("quad_gre", $signed(gamma_re), 64'sd0);
      chk("quad_gim", $signed(gamma_im), 64'sd160000);
      chk("quad_phi", {{(64-AW){1'b0}}, phi}, 64'sd160000);
      chk("quad_wf", {63'd0, window_full}, 64'sd1);

      phase = "slide";
      do_reset(2);
      for (int k = 1; k <= 16; k++) cyc(1'b1, 100, 0, 100, 0);
      for (int k = 1; k <= 16; k++) cyc(1'b1, 0, 0, 0, 0);
      cyc(1'b0, 0, 0, 0, 0);
      chk("slide_gre_end", $signed(gamma_re), 64'sd0);
      chk("slide_wf", {63'd0, window_full}, 64'sd1);

      phase = "gapped";
      do_reset(2);
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b1, 100, 0, 100, 0);
         cyc(1'b0, 0, 0, 0, 0);
      end
      chk("gap_gre", $signed(gamma_re), 64'sd160000);
      chk("gap_phi", {{(64-AW){1'b0}}, phi}, 64'sd160000);

      phase = "extreme";
      do_reset(2);
      for (int k = 1; k <= 21; k++) cyc(1'b1, -32768, -32768, -32768, -32768);
      cyc(1'b0, 0, 0, 0, 0);
      chk("ext_gre", $signed(gamma_re), 64'sd34359738368);
      chk("ext_gim", $signed(gamma_im), 64'sd0);
      chk("ext_phi", {{(64-AW){1'b0}}, phi}, 64'sd34359738368);

      phase = "midreset";
      for (int k = 1; k <= 10; k++) cyc(1'b1, rnd(), rnd(), rnd(), rnd());
      do_reset(2);
      chk("mid_wf0", {63'd0, window_full}, 64'sd0);
      for (int k = 1; k <= 15; k++) cyc(1'b1, 100, 0, 100, 0);
      cyc(1'b0, 0, 0, 0, 0);
      chk("mid_wf_after15", {63'd0, window_full}, 64'sd0);
      cyc(1'b1, 100, 0, 100, 0);
      cyc(1'b0, 0, 0, 0, 0);
      chk("mid_wf_after16", {63'd0, window_full}, 64'sd1);

      phase = "random";
      do_reset(2);
      for (int k = 0; k < 120; k++)
         cyc($urandom_range(0, 3) != 0, rnd(), rnd(), rnd(), rnd());
      cyc(1'b0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cp_corr_window.md
Name: cp_corr_window

Overview:
- Consumes the aligned sample pair (r[n], r[n-N]) produced by the delay_n stage.
- Computes the sliding-window cyclic-prefix correlation over the last L accepted samples:
  - gamma[n] = sum of r[k]·conj(r[k-N])
  - phi[n] = ½·sum of (|r[k]|² + |r[k-N]|²)
- Feeds the downstream timing/CFO metric stage, which forms |gamma| − rho·phi and the argmax.
- Valid-qualified pipeline; no backpressure.

Parameters:
- DW, 16: sample width; r_t is signed [DW-1:0], defined in the shared package.
- L, 16: correlation window length (CP length); must be ≥ 2.
- LW, $clog2(L)+1: width of the fill counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pair valid; driven by delay_n_valid.
- r_real  in  DW  r[n] real part.
- r_imag  in  DW  r[n] imaginary part.
- r_dN_real  in  DW  r[n-N] real part.
- r_dN_imag  in  DW  r[n-N] imaginary part.
- corr_valid  out  1  output strobe; one pulse per accepted input.
- gamma_re  out  AW  signed windowed correlation, real part; AW = 2·DW+1+$clog2(L).
- gamma_im  out  AW  signed windowed correlation, imaginary part.
- phi  out  AW  unsigned windowed energy, halved.
- window_full  out  1  high once L samples have been accumulated.

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs go to 0.
  - Accumulators, circular buffer contents, write pointer and fill counter go to 0.
- Stage 1 (registered; executes only when in_valid=1):
  - pr = r_re·dN_re + r_im·dN_im (signed, 2DW+1 bits).
  - pi = r_im·dN_re − r_re·dN_im (signed, 2DW+1 bits).
  - e = r_re² + r_im² + dN_re² + dN_im² (unsigned, 2DW+1 bits).
  - s1_valid <= in_valid.
- Stage 2 (executes only when s1_valid=1):
  - Read the oldest entry (opr, opi, oe) from buffer[wr_ptr].
  - Write (pr, pi, e) into buffer[wr_ptr].
  - Advance wr_ptr; it wraps from L-1 to 0.
  - acc_re += pr − opr; acc_im += pi − opi; acc_e += e − oe.
  - The buffer is zero after reset, so the first L samples subtract 0 and no special case is needed.
- Outputs:
  - gamma_re = acc_re, gamma_im = acc_im.
  - phi = acc_e >> 1 (logical shift, floor).
  - All outputs are registered, updated on the same edge as the accumulators.
- Latency: corr_valid pulses exactly 2 cycles after the edge at which in_valid was sampled high.
- Output hold:
  - Outputs hold their values when corr_valid=0.
  - corr_valid is a single-cycle pulse per accepted sample.
- Gaps in in_valid:
  - No state advances.
  - The output sequence for gapped input is identical to the contiguous case; only timing differs.
- Fill counter and window_full:
  - The counter increments per stage-2 update and saturates at L.
  - window_full goes high together with the corr_valid of the L-th accepted sample.
  - window_full stays high until reset.
- Width: AW holds the worst case (all inputs −2^(DW-1)) without overflow; no saturation logic is required.
- Reset mid-operation: the pipeline is flushed, any in-flight sample is discarded, and the window restarts empty.
- Back-to-back samples: one update per cycle, full throughput.

Decomposition:
- Package data_type.svh additions:
  - DW
  - prod_t (signed 2DW+1)
  - energy_t (unsigned 2DW+1)
  - acc_t (signed AW)
  - function clog2 if not already present
- Sub-module cplx_conj_mult: stage-1 registered pr/pi/e computation with valid pass-through.
- Top level: circular buffer, accumulators and fill counter.

Test Plan:
- Reset:
  - Stimulus: assert rst with random inputs and in_valid=1.
  - Required: all outputs are 0 and no corr_valid pulses while rst is high.
- Ramp to steady state:
  - Stimulus: r=(100,0), dN=(100,0) for 20 contiguous samples.
  - Required: k-th output has gamma_re=10000·min(k,16), gamma_im=0, phi=10000·min(k,16).
  - Required: window_full rises at k=16.
- Quadrature:
  - Stimulus: r=(0,100), dN=(100,0) for 16 samples.
  - Required: gamma_re=0, gamma_im=160000, phi=160000 at k=16.
- Sliding window:
  - Stimulus: 16 samples of r=dN=(100,0), then 16 samples of r=dN=(0,0).
  - Required: gamma_re decreases by 10000 per sample and reaches 0 at sample 32; window_full stays 1.
- Gapped input:
  - Stimulus: ramp stimulus with in_valid toggling 1/0.
  - Required: same value sequence as the contiguous case; each corr_valid occurs exactly 2 cycles after its accepted in_valid.
- Extremes and mid-run reset:
  - Stimulus: all inputs −32768 for 21 samples.
  - Required: gamma_re=2^35 with no wrap; gamma_im=0; phi=2^35.
  - Stimulus: then rst pulsed after sample 10 of a new run.
  - Required: outputs 0, window_full=0, and 16 new samples are needed before window_full rises again.
